shifter_w_parallel_load: RTL and testbench
==========================================

Name: shifter_w_parallel_load

Overview:
- Parameterised universal shift register with synchronous parallel load, hold, shift-right and shift-left modes.
- A 2-bit mode select chooses one operation per clock.
- Serial inputs feed the vacated end bit.
- Used as a general datapath register in small control and serialisation paths. The register contents are always visible on Y_o.

Parameters:
- WIDTH, 8, register and data width in bits; must be >= 2.

Ports:
- Clk  input  1  rising-edge clock; the only clock.
- Rst  input  1  synchronous reset, active-high.
- data_i  input  WIDTH  parallel load data.
- data_L  input  1  left serial input; enters MSB on shift-right.
- data_R  input  1  right serial input; enters LSB on shift-left.
- S_i  input  2  mode select.
- Y_o  output  WIDTH  register contents, driven directly from flops.

Behaviour:
- Single register Q[WIDTH-1:0]. Y_o = Q with no combinational path from the inputs.
- All updates occur on the rising edge of Clk.
- Reset: if Rst = 1 at a rising edge, Q <= 0 regardless of S_i or the data inputs. Reset has highest priority and may be asserted mid-operation; the next edge still loads zero.
- Reset value of Y_o is all zeros. Before the first reset edge, contents are undefined; no power-up value is required.
- Mode when Rst = 0:
  - S_i = 2'b00, hold: Q <= Q.
  - S_i = 2'b01, parallel load: Q <= data_i.
  - S_i = 2'b10, shift right: Q <= {data_L, Q[WIDTH-1:1]}. Q[0] is discarded.
  - S_i = 2'b11, shift left: Q <= {Q[WIDTH-2:0], data_R}. Q[WIDTH-1] is discarded.
- Latency: the effect of an operation is visible on Y_o one cycle after the sampling edge; each edge performs exactly one operation.
- Serial input inactive in the current mode (data_R during shift-right, data_L during shift-left, both during hold/load) is ignored.
- data_i is ignored in every mode except load.
- No handshake; S_i may change every cycle. Back-to-back mode changes are legal and take effect on the next edge.
- X or Z on S_i is not supported; behaviour is unspecified. The bench must drive known values.
- No wrap-around or saturation: bits shifted out are lost unless the optional feature is enabled.

Optional Feature:
- Macro SHIFTER_W_PARALLEL_LOAD_ROTATE_EN.
- When defined:
  - Adds input port rot_i (1 bit).
  - With rot_i = 1, shift-right becomes rotate-right: Q <= {Q[0], Q[WIDTH-1:1]}.
  - With rot_i = 1, shift-left becomes rotate-left: Q <= {Q[WIDTH-2:0], Q[WIDTH-1]}.
  - The serial inputs are ignored while rotating.
  - With rot_i = 0, behaviour is identical to the base design.
  - Hold, load and reset are unaffected.
- When not defined: the rot_i port does not exist and behaviour is exactly as specified in Behaviour.

Test Plan:
- Reset: Rst = 1 for 1 edge with S_i = 01, data_i = 8'hFF -> Y_o = 8'h00. Release Rst with S_i = 00 -> Y_o stays 8'h00.
- Load then hold: S_i = 01, data_i = 8'h01 for 1 edge -> Y_o = 8'h01. Then S_i = 00 with data_i = 8'hAA for 3 edges -> Y_o stays 8'h01.
- Shift right: from 8'h01, S_i = 10.
  - data_L = 1 for 1 edge -> 8'h80.
  - Then data_L = 0 for 7 edges -> 8'h40, 8'h20 ... 8'h01.
  - One more edge -> 8'h00.
- Shift left: from 8'h01, S_i = 11.
  - data_R = 1 for 1 edge -> 8'h03.
  - Then data_R = 0 for 7 edges -> 8'h06, 8'h0C ... 8'h80.
  - Next edge -> 8'h00.
  - data_L toggling throughout has no effect.
- Reset mid-shift: during an S_i = 10 sequence holding 8'h30, assert Rst for 1 edge -> 8'h00. Deassert and continue S_i = 10 with data_L = 1 -> 8'h80.
- Rotate, with macro defined and rot_i = 1: load 8'h81. S_i = 10 for 1 edge -> 8'hC0. S_i = 11 for 2 edges -> 8'h81, then 8'h03.

Source files
------------

// File: rtl/shifter_w_parallel_load_if.sv
// ---------------------------------------------------------------------------
// shifter_w_parallel_load_if
//   Bus bundle for the universal shift register.
//
//   Signals:
//     data_i  [WIDTH-1:0]  parallel load data
//     data_L               left serial input (enters MSB on shift-right)
//     data_R               right serial input (enters LSB on shift-left)
//     S_i     [1:0]        mode select: 00 hold, 01 load, 10 shr, 11 shl
//     rot_i                rotate enable (only with SHIFTER_W_PARALLEL_LOAD_ROTATE_EN)
//     Y_o     [WIDTH-1:0]  register contents
//
//   Modports:
//     master  drives the controls and data, observes Y_o
//     slave   the register itself
//
//   Handshake: none. Every rising clock edge consumes S_i and performs
//   exactly one operation. S_i may change on any cycle.
// ---------------------------------------------------------------------------
interface shifter_w_parallel_load_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_i;
    logic             data_L;
    logic             data_R;
    logic [1:0]       S_i;
`ifdef SHIFTER_W_PARALLEL_LOAD_ROTATE_EN
    logic             rot_i;
`endif
    logic [WIDTH-1:0] Y_o;

    modport master (
        output data_i,
        output data_L,
        output data_R,
        output S_i,
`ifdef SHIFTER_W_PARALLEL_LOAD_ROTATE_EN
        output rot_i,
`endif
        input  Y_o
    );

    modport slave (
        input  data_i,
        input  data_L,
        input  data_R,
        input  S_i,
`ifdef SHIFTER_W_PARALLEL_LOAD_ROTATE_EN
        input  rot_i,
`endif
        output Y_o
    );
endinterface

// File: rtl/shifter_w_parallel_load.sv
// ---------------------------------------------------------------------------
// shifter_w_parallel_load
//   Universal shift register: hold, parallel load, shift right, shift left.
//   One operation per rising edge of Clk; result visible on Y_o after it.
//
//   Ports:
//     Clk   rising-edge clock
//     Rst   synchronous reset, active-high, highest priority (Q <= 0)
//     bus   shifter_w_parallel_load_if.slave (data_i, data_L, data_R, S_i,
//           Y_o, and rot_i when the rotate option is built in)
//
//   Optional feature:
//     SHIFTER_W_PARALLEL_LOAD_ROTATE_EN  adds rot_i; with rot_i = 1 the shift
//     modes recirculate the bit falling off the far end instead of taking
//     the serial input.
//
//   Parameters:
//     WIDTH  register width in bits (>= 2)
// ---------------------------------------------------------------------------
module shifter_w_parallel_load #(
    parameter int WIDTH = 8
) (
    input  logic                    Clk,
    input  logic                    Rst,
    shifter_w_parallel_load_if.slave bus
);

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_LOAD = 2'b01;
    localparam logic [1:0] MODE_SHR  = 2'b10;
    localparam logic [1:0] MODE_SHL  = 2'b11;

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             fill_msb;   // bit entering at the MSB on shift-right
    logic             fill_lsb;   // bit entering at the LSB on shift-left

    // Choose what fills the vacated end bit.
    always_comb begin
        fill_msb = bus.data_L;
        fill_lsb = bus.data_R;
`ifdef SHIFTER_W_PARALLEL_LOAD_ROTATE_EN
        if (bus.rot_i) begin
            fill_msb = q_q[0];
            fill_lsb = q_q[WIDTH-1];
        end
`endif
    end

    always_comb begin
        q_d = q_q;
        unique case (bus.S_i)
            MODE_HOLD: q_d = q_q;
            MODE_LOAD: q_d = bus.data_i;
            MODE_SHR:  q_d = {fill_msb, q_q[WIDTH-1:1]};
            MODE_SHL:  q_d = {q_q[WIDTH-2:0], fill_lsb};
            default:   q_d = q_q;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign bus.Y_o = q_q;

endmodule

// File: tb/tb_shifter_w_parallel_load.sv
module tb_shifter_w_parallel_load;

    localparam int WIDTH = 8;

    // ---------------- clock / reset ----------------
    logic Clk;
    logic Rst;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    shifter_w_parallel_load_if #(.WIDTH(WIDTH)) bus ();

    shifter_w_parallel_load #(.WIDTH(WIDTH)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus.slave)
    );

    int checks;
    int errors;

    // ---------------- driver ----------------
    // Drive one cycle's inputs, let one rising edge happen, then settle
    // #1 past the edge so the outputs are sampled away from it.
    task automatic drive(input logic rst, input logic [1:0] s,
                         input logic [WIDTH-1:0] d,
                         input logic l, input logic r);
        Rst        = rst;
        bus.S_i    = s;
        bus.data_i = d;
        bus.data_L = l;
        bus.data_R = r;
        @(posedge Clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        drive(1'b1, 2'b01, 8'hFF, 1'b1, 1'b1);
        checks++;
        if (bus.Y_o !== 8'h00) begin
            errors++;
            $display("FAIL reset_load_ignored got %h exp %h", bus.Y_o, 8'h00);
        end
        drive(1'b0, 2'b00, 8'hFF, 1'b1, 1'b1);
        checks++;
        if (bus.Y_o !== 8'h00) begin
            errors++;
            $display("FAIL reset_release_hold got %h exp %h", bus.Y_o, 8'h00);
        end
    endtask

    task automatic test_load_hold();
        drive(1'b0, 2'b01, 8'h01, 1'b0, 1'b0);
        checks++;
        if (bus.Y_o !== 8'h01) begin
            errors++;
            $display("FAIL load got %h exp %h", bus.Y_o, 8'h01);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'b00, 8'hAA, i[0], ~i[0]);
            checks++;
            if (bus.Y_o !== 8'h01) begin
                errors++;
                $display("FAIL hold[%0d] got %h exp %h", i, bus.Y_o, 8'h01);
            end
        end
    endtask

    task automatic test_shift_right();
        logic [WIDTH-1:0] exp_shr [9];
        exp_shr = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00};
        drive(1'b0, 2'b01, 8'h01, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            // data_R and data_i toggle as noise; only data_L matters here
            drive(1'b0, 2'b10, (i[0] ? 8'hFF : 8'h5A), (i == 0), i[0]);
            checks++;
            if (bus.Y_o !== exp_shr[i]) begin
                errors++;
                $display("FAIL shr[%0d] got %h exp %h", i, bus.Y_o, exp_shr[i]);
            end
        end
    endtask

    task automatic test_shift_left();
        logic [WIDTH-1:0] exp_shl [9];
        exp_shl = '{8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h80, 8'h00};
        drive(1'b0, 2'b01, 8'h01, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            // data_L toggles throughout and must have no effect
            drive(1'b0, 2'b11, 8'hA5, i[0], (i == 0));
            checks++;
            if (bus.Y_o !== exp_shl[i]) begin
                errors++;
                $display("FAIL shl[%0d] got %h exp %h", i, bus.Y_o, exp_shl[i]);
            end
        end
    endtask

    task automatic test_reset_mid_shift();
        drive(1'b0, 2'b01, 8'h60, 1'b0, 1'b0);
        drive(1'b0, 2'b10, 8'h00, 1'b0, 1'b1);
        checks++;
        if (bus.Y_o !== 8'h30) begin
            errors++;
            $display("FAIL mid_shift_pre got %h exp %h", bus.Y_o, 8'h30);
        end
        drive(1'b1, 2'b10, 8'hFF, 1'b1, 1'b1);
        checks++;
        if (bus.Y_o !== 8'h00) begin
            errors++;
            $display("FAIL mid_shift_reset got %h exp %h", bus.Y_o, 8'h00);
        end
        drive(1'b0, 2'b10, 8'hFF, 1'b1, 1'b0);
        checks++;
        if (bus.Y_o !== 8'h80) begin
            errors++;
            $display("FAIL mid_shift_resume got %h exp %h", bus.Y_o, 8'h80);
        end
    endtask

    // Mode changes on every edge: load, shl, shr, hold, load, shr.
    task automatic test_back_to_back();
        logic [1:0]       s_v   [6];
        logic [WIDTH-1:0] d_v   [6];
        logic             l_v   [6];
        logic             r_v   [6];
        logic [WIDTH-1:0] exp_v [6];
        s_v   = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b10};
        d_v   = '{8'hA5, 8'h00, 8'h33, 8'hFF, 8'h3C, 8'h00};
        l_v   = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b1,  1'b0};
        r_v   = '{1'b1,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1};
        // A5 -shl(1)-> 4B -shr(1)-> A5 -hold-> A5 -load-> 3C -shr(0)-> 1E
        exp_v = '{8'hA5, 8'h4B, 8'hA5, 8'hA5, 8'h3C, 8'h1E};
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, s_v[i], d_v[i], l_v[i], r_v[i]);
            checks++;
            if (bus.Y_o !== exp_v[i]) begin
                errors++;
                $display("FAIL b2b[%0d] got %h exp %h", i, bus.Y_o, exp_v[i]);
            end
        end
    endtask

`ifdef SHIFTER_W_PARALLEL_LOAD_ROTATE_EN
    task automatic test_rotate();
        logic [1:0]       s_v   [3];
        logic [WIDTH-1:0] exp_v [3];
        s_v   = '{2'b10, 2'b11, 2'b11};
        exp_v = '{8'hC0, 8'h81, 8'h03};
        bus.rot_i = 1'b1;
        drive(1'b0, 2'b01, 8'h81, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            // serial inputs held opposite to the recirculated bit
            drive(1'b0, s_v[i], 8'h00, 1'b0, 1'b0);
            checks++;
            if (bus.Y_o !== exp_v[i]) begin
                errors++;
                $display("FAIL rot[%0d] got %h exp %h", i, bus.Y_o, exp_v[i]);
            end
        end
        bus.rot_i = 1'b0;
        drive(1'b0, 2'b10, 8'h00, 1'b1, 1'b0);
        checks++;
        if (bus.Y_o !== 8'h81) begin
            errors++;
            $display("FAIL rot_off_shr got %h exp %h", bus.Y_o, 8'h81);
        end
    endtask
`endif

    // ---------------- sequence + report ----------------
    initial begin
        checks     = 0;
        errors     = 0;
        Rst        = 1'b1;
        bus.S_i    = 2'b00;
        bus.data_i = '0;
        bus.data_L = 1'b0;
        bus.data_R = 1'b0;
`ifdef SHIFTER_W_PARALLEL_LOAD_ROTATE_EN
        bus.rot_i  = 1'b0;
`endif
        test_reset();
        test_load_hold();
        test_shift_right();
        test_shift_left();
        test_reset_mid_shift();
        test_back_to_back();
`ifdef SHIFTER_W_PARALLEL_LOAD_ROTATE_EN
        test_rotate();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
